mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Round-robin arbiter that shares the single-ported, fixed-latency, non-blocking line memory between NUM_PORTS requesters, e.g. instruction fetch and load/store queue. Each accepted request is tagged with its port index in the upper bits of the memory request ID. Each memory response is steered back to the owning port using that tag. Per-port outstanding-read credits bound the number of reads in flight.

## Interface
- NUM_PORTS, 2: number of requesters; must equal 2**PORT_BITS.
- PORT_BITS, 1: log2(NUM_PORTS).
- ADDR_WIDTH, 32: address width.
- LINE_WIDTH, 32: data width.
- REQ_ID_BITS, 3: requester-side ID width. Memory ID width is PORT_BITS+REQ_ID_BITS.
- MAX_OUTSTANDING, 8: maximum reads in flight per port.
- CNT_BITS, 4: credit counter width; must hold MAX_OUTSTANDING.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_rw  in  NUM_PORTS  1 = write, 0 = read.
- req_addr  in  NUM_PORTS*ADDR_WIDTH  port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_data  in  NUM_PORTS*LINE_WIDTH  write data, packed the same way.
- req_id  in  NUM_PORTS*REQ_ID_BITS  request ID, packed the same way.
- req_stall  out  NUM_PORTS  combinational; high means the port's request is not accepted this cycle.
- rsp_valid  out  NUM_PORTS  read data for port i valid this cycle.
- rsp_data  out  LINE_WIDTH  response data, shared by all ports.
- rsp_id  out  REQ_ID_BITS  REQ_ID_BITS of the response, shared by all ports.
- mem_valid, mem_rw  out  1  request to memory.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  LINE_WIDTH  memory write data.
- mem_id  out  PORT_BITS+REQ_ID_BITS  {port, req_id}.
- mem_stall  in  1  memory cannot accept requests.
- mem_ready  in  1  read response valid.
- mem_rdata  in  LINE_WIDTH  read response data.
- mem_rid  in  PORT_BITS+REQ_ID_BITS  read response ID.

## Operation
- Eligibility: port i is eligible when req_valid[i]=1 and either req_rw[i]=1 or cnt[i] < MAX_OUTSTANDING.
- Writes consume no credit because memory returns no write response.
- Grant: when mem_stall=0, grant the first eligible port scanning ptr, ptr+1, … mod NUM_PORTS. When mem_stall=1, grant nothing.
- req_stall[i] = req_valid[i] & ~grant[i]. It is 0 whenever req_valid[i]=0.
- Pointer: after a grant to port p, ptr ← (p+1) mod NUM_PORTS. With no grant, ptr holds.
- Issue register: on a grant, the next edge loads mem_valid=1, mem_rw, mem_addr, mem_wdata and mem_id={p, req_id[p]}.
- Without a grant, mem_valid←0 and the other issue fields hold their values.
- Credits, per port p:
  - inc = granted read from p.
  - dec = mem_ready & mem_rid[top PORT_BITS]==p.
  - inc only: cnt+1. dec only: cnt−1, saturating at 0. Both: unchanged.
- Response steering: on mem_ready, the next edge sets rsp_valid to the one-hot of mem_rid's port field and loads rsp_data←mem_rdata and rsp_id←mem_rid[REQ_ID_BITS-1:0].
- Without mem_ready, rsp_valid←0 and rsp_data/rsp_id hold.
- Responses are never back-pressured. Requesters must accept rsp_valid in the cycle it is asserted.
- Reset (async, any time, including mid-flight): in-flight responses are dropped, and memory is reset by the same signal.

## Timing
- Reset values: mem_valid 0, mem_rw 0, mem_addr 0, mem_wdata 0, mem_id 0, rsp_valid 0, rsp_data 0, rsp_id 0, ptr 0, all cnt 0.
- Arbitration is combinational. Request accepted at edge T drives mem_valid at T+1.
- Response latency through the arbiter: rsp_valid asserted one cycle after mem_ready.
- End-to-end read latency = 2 + memory latency.
- Throughput: one request per cycle total, with no bubble between back-to-back grants.
- Simultaneous grant and response to the same port in one cycle: the credit count is unchanged.

## Test plan
- Reset: assert reset low mid-traffic -> all outputs 0 immediately; after release, first request from port 0 with ptr=0 is granted.
- Single read: port 1 read addr 0x40, id 5 -> mem_id=0b1_101 next cycle; memory returns mem_ready with that ID -> rsp_valid=2'b10, rsp_id=5 one cycle later.
- Contention: both ports issue reads continuously -> grants alternate 0,1,0,1 and mem_valid stays high every cycle.
- Credit limit: port 0 issues 9 reads with responses withheld -> first 8 accepted, 9th shows req_stall[0]=1; one response releases it next cycle, and port 1 still flows meanwhile.
- Writes: port 0 issues 12 back-to-back writes -> never stalled for credit, cnt[0] stays 0, no rsp_valid.
- mem_stall: hold mem_stall=1 with both ports valid -> req_stall=2'b11, mem_valid=0, ptr unchanged; on deassert, grant resumes at ptr.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one fixed-latency, non-blocking
// line memory between NUM_PORTS requesters. Accepted requests are tagged with
// the port index in the upper mem_id bits; read responses are steered back by
// that tag. Per-port read credits bound the number of reads in flight.
module mem_port_arbiter #(
    parameter int NUM_PORTS       = 2,
    parameter int PORT_BITS       = 1,
    parameter int ADDR_WIDTH      = 32,
    parameter int LINE_WIDTH      = 32,
    parameter int REQ_ID_BITS     = 3,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_BITS        = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              req_valid,
    input  logic [NUM_PORTS-1:0]              req_rw,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_PORTS*LINE_WIDTH-1:0]   req_data,
    input  logic [NUM_PORTS*REQ_ID_BITS-1:0]  req_id,
    output logic [NUM_PORTS-1:0]              req_stall,
    output logic [NUM_PORTS-1:0]              rsp_valid,
    output logic [LINE_WIDTH-1:0]             rsp_data,
    output logic [REQ_ID_BITS-1:0]            rsp_id,
    output logic                              mem_valid,
    output logic                              mem_rw,
    output logic [ADDR_WIDTH-1:0]             mem_addr,
    output logic [LINE_WIDTH-1:0]             mem_wdata,
    output logic [PORT_BITS+REQ_ID_BITS-1:0]  mem_id,
    input  logic                              mem_stall,
    input  logic                              mem_ready,
    input  logic [LINE_WIDTH-1:0]             mem_rdata,
    input  logic [PORT_BITS+REQ_ID_BITS-1:0]  mem_rid
);

    localparam int MID_BITS = PORT_BITS + REQ_ID_BITS;
    localparam logic [CNT_BITS-1:0] MAX_CNT = CNT_BITS'(MAX_OUTSTANDING);

    logic [PORT_BITS-1:0]   ptr_q, ptr_d;
    logic [CNT_BITS-1:0]    cnt_q [NUM_PORTS];

    logic                   mem_valid_q, mem_rw_q;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic [LINE_WIDTH-1:0]  mem_wdata_q;
    logic [MID_BITS-1:0]    mem_id_q;

    logic [NUM_PORTS-1:0]   rsp_valid_q;
    logic [LINE_WIDTH-1:0]  rsp_data_q;
    logic [REQ_ID_BITS-1:0] rsp_id_q;

    logic [NUM_PORTS-1:0]   eligible, grant, cnt_inc, cnt_dec, rsp_onehot;
    logic                   gnt_any;
    logic [PORT_BITS-1:0]   gnt_port, scan_idx, rsp_port;
    logic                   sel_rw;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [LINE_WIDTH-1:0]  sel_data;
    logic [REQ_ID_BITS-1:0] sel_id;

    assign rsp_port = mem_rid[MID_BITS-1 -: PORT_BITS];

    // Eligibility: writes always eligible, reads only while credit remains
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = req_valid[i] & (req_rw[i] | (cnt_q[i] < MAX_CNT));
        end
    end

    // Round-robin scan starting at ptr; index arithmetic wraps mod NUM_PORTS
    always_comb begin
        grant    = '0;
        gnt_any  = 1'b0;
        gnt_port = '0;
        scan_idx = '0;
        if (!mem_stall) begin
            for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                scan_idx = ptr_q + PORT_BITS'(k);
                if (!gnt_any && eligible[scan_idx]) begin
                    gnt_any  = 1'b1;
                    gnt_port = scan_idx;
                end
            end
        end
        if (gnt_any) begin
            grant[gnt_port] = 1'b1;
        end
        ptr_d = gnt_any ? gnt_port + PORT_BITS'(1) : ptr_q;
    end

    assign req_stall = req_valid & ~grant;

    // Select the granted port's request fields and derive credit events
    always_comb begin
        sel_rw     = req_rw[gnt_port];
        sel_addr   = req_addr[int'(gnt_port)*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data   = req_data[int'(gnt_port)*LINE_WIDTH +: LINE_WIDTH];
        sel_id     = req_id[int'(gnt_port)*REQ_ID_BITS +: REQ_ID_BITS];
        cnt_inc    = grant & ~req_rw;
        cnt_dec    = '0;
        rsp_onehot = '0;
        if (mem_ready) begin
            cnt_dec[rsp_port]    = 1'b1;
            rsp_onehot[rsp_port] = 1'b1;
        end
    end

    // Issue register and round-robin pointer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_id_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            mem_valid_q <= gnt_any;
            if (gnt_any) begin
                mem_rw_q    <= sel_rw;
                mem_addr_q  <= sel_addr;
                mem_wdata_q <= sel_data;
                mem_id_q    <= {gnt_port, sel_id};
            end
        end
    end

    // Per-port outstanding-read credit counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (cnt_inc[i] && !cnt_dec[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_BITS'(1);
                end else if (!cnt_inc[i] && cnt_dec[i] && cnt_q[i] != '0) begin
                    cnt_q[i] <= cnt_q[i] - CNT_BITS'(1);
                end
            end
        end
    end

    // Response steering register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_onehot;
            if (mem_ready) begin
                rsp_data_q <= mem_rdata;
                rsp_id_q   <= mem_rid[REQ_ID_BITS-1:0];
            end
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_id    = mem_id_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed phases followed by random traffic, checked
// against a transaction-level model (pointer, credit counts, expected issue
// and response values) plus a fixed-latency memory model with a response queue.
module tb_mem_port_arbiter;

    localparam int NP  = 2;
    localparam int PB  = 1;
    localparam int AW  = 32;
    localparam int LW  = 32;
    localparam int IB  = 3;
    localparam int MO  = 8;
    localparam int CB  = 4;
    localparam int MB  = PB + IB;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic [NP-1:0]     req_valid, req_rw, req_stall, rsp_valid;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*LW-1:0]  req_data;
    logic [NP*IB-1:0]  req_id;
    logic [LW-1:0]     rsp_data;
    logic [IB-1:0]     rsp_id;
    logic              mem_valid, mem_rw, mem_stall, mem_ready;
    logic [AW-1:0]     mem_addr;
    logic [LW-1:0]     mem_wdata, mem_rdata;
    logic [MB-1:0]     mem_id, mem_rid;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .NUM_PORTS(NP), .PORT_BITS(PB), .ADDR_WIDTH(AW), .LINE_WIDTH(LW),
        .REQ_ID_BITS(IB), .MAX_OUTSTANDING(MO), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_rw(req_rw), .req_addr(req_addr),
        .req_data(req_data), .req_id(req_id), .req_stall(req_stall),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_id(mem_id), .mem_stall(mem_stall),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rid(mem_rid)
    );

    typedef struct {
        logic [MB-1:0] id;
        logic [LW-1:0] data;
        int            due;
    } rsp_t;

    // Stimulus for the next cycle
    logic [NP-1:0] s_valid, s_rw;
    logic [AW-1:0] s_addr [NP];
    logic [LW-1:0] s_data [NP];
    logic [IB-1:0] s_id   [NP];
    logic          s_stall;
    bit            hold;
    int            rel;

    // Reference model state
    int            m_ptr;
    int            m_cnt [NP];
    logic          e_mv, e_rw;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata, e_rdata;
    logic [MB-1:0] e_id;
    logic [NP-1:0] e_rv;
    logic [IB-1:0] e_rid;
    rsp_t          mq[$];
    int            cyc;
    logic [NP-1:0] last_stall;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int p = 0; p < NP; p++) m_cnt[p] = 0;
        e_mv = 0; e_rw = 0; e_addr = '0; e_wdata = '0; e_id = '0;
        e_rv = '0; e_rdata = '0; e_rid = '0;
        mq.delete();
    endtask

    task automatic set_idle();
        s_valid = '0; s_rw = '0; s_stall = 1'b0;
        for (int p = 0; p < NP; p++) begin
            s_addr[p] = '0; s_data[p] = '0; s_id[p] = '0;
        end
    endtask

    task automatic set_random();
        for (int p = 0; p < NP; p++) begin
            s_valid[p] = ($urandom_range(0, 3) != 0);
            s_rw[p]    = ($urandom_range(0, 2) == 0);
            s_addr[p]  = $urandom;
            s_data[p]  = $urandom;
            s_id[p]    = IB'($urandom);
        end
        s_stall = ($urandom_range(0, 4) == 0);
    endtask

    task automatic check_outputs(input string ph);
        chk({ph, ".mem_valid"}, mem_valid, e_mv);
        chk({ph, ".mem_rw"},    mem_rw,    e_rw);
        chk({ph, ".mem_addr"},  mem_addr,  e_addr);
        chk({ph, ".mem_wdata"}, mem_wdata, e_wdata);
        chk({ph, ".mem_id"},    mem_id,    e_id);
        chk({ph, ".rsp_valid"}, rsp_valid, e_rv);
        chk({ph, ".rsp_data"},  rsp_data,  e_rdata);
        chk({ph, ".rsp_id"},    rsp_id,    e_rid);
    endtask

    // One clock cycle: drive, check combinational stall, clock, update model, check registers
    task automatic step(input string ph);
        int            g;
        int            p;
        int            rp;
        logic          rdy;
        logic [LW-1:0] rd;
        logic [MB-1:0] rid;
        logic [NP-1:0] exp_stall;
        @(negedge clk);
        req_valid = s_valid;
        req_rw    = s_rw;
        for (int q = 0; q < NP; q++) begin
            req_addr[q*AW +: AW] = s_addr[q];
            req_data[q*LW +: LW] = s_data[q];
            req_id[q*IB +: IB]   = s_id[q];
        end
        mem_stall = s_stall;
        rdy = 1'b0; rd = $urandom; rid = MB'($urandom);
        if (mq.size() > 0 && mq[0].due <= cyc && (!hold || rel > 0)) begin
            rdy = 1'b1; rd = mq[0].data; rid = mq[0].id;
            void'(mq.pop_front());
            if (hold) rel--;
        end
        mem_ready = rdy; mem_rdata = rd; mem_rid = rid;
        rp = int'(rid[MB-1 -: PB]);

        g = -1;
        if (!s_stall) begin
            for (int k = 0; k < NP; k++) begin
                p = (m_ptr + k) % NP;
                if (g < 0 && s_valid[p] && (s_rw[p] || m_cnt[p] < MO)) g = p;
            end
        end
        exp_stall = s_valid;
        if (g >= 0) exp_stall[g] = 1'b0;
        #1;
        chk({ph, ".req_stall"}, req_stall, exp_stall);
        last_stall = req_stall;

        @(posedge clk);
        if (e_mv && !e_rw) mq.push_back('{e_id, LW'($urandom), cyc + LAT});
        for (int q = 0; q < NP; q++) begin
            if (g == q && !s_rw[q] && !(rdy && rp == q)) m_cnt[q]++;
            else if (!(g == q && !s_rw[q]) && rdy && rp == q && m_cnt[q] > 0) m_cnt[q]--;
        end
        if (g >= 0) begin
            e_mv = 1; e_rw = s_rw[g]; e_addr = s_addr[g]; e_wdata = s_data[g];
            e_id = {PB'(g), s_id[g]};
            m_ptr = (g + 1) % NP;
        end else begin
            e_mv = 0;
        end
        e_rv = '0;
        if (rdy) begin
            e_rv[rp] = 1'b1; e_rdata = rd; e_rid = rid[IB-1:0];
        end
        cyc++;
        #1;
        check_outputs(ph);
    endtask

    task automatic idle_steps(input string ph, input int n);
        set_idle();
        for (int i = 0; i < n; i++) step(ph);
    endtask

    initial begin
        cyc = 0; hold = 0; rel = 0; last_stall = '0;
        set_idle();
        model_reset();
        req_valid = '0; req_rw = '0; req_addr = '0; req_data = '0; req_id = '0;
        mem_stall = 1'b0; mem_ready = 1'b0; mem_rdata = '0; mem_rid = '0;

        // Power-on reset
        reset = 1'b1;
        #2 reset = 1'b0;
        #1 check_outputs("reset");
        @(negedge clk); @(negedge clk);
        reset = 1'b1;

        // Single read from port 1
        set_idle();
        s_valid = 2'b10; s_addr[1] = 32'h40; s_id[1] = 3'd5;
        step("single");
        chk("single.mem_id_tag", mem_id, 4'b1101);
        set_idle();
        for (int i = 0; i < LAT + 1; i++) step("single_wait");
        chk("single.rsp_valid", rsp_valid, 2'b10);
        chk("single.rsp_id", rsp_id, 3'd5);

        // Contention: both ports read every cycle
        for (int i = 0; i < 10; i++) begin
            set_random();
            s_valid = 2'b11; s_rw = 2'b00; s_stall = 1'b0;
            step("contend");
            chk("contend.mem_valid_high", mem_valid, 1'b1);
        end
        idle_steps("drain", 10);

        // Credit limit: port 0 reads with responses withheld, port 1 writes
        hold = 1; rel = 0;
        for (int i = 0; i < 20; i++) begin
            set_random();
            s_valid = 2'b11; s_rw = 2'b10; s_stall = 1'b0;
            step("credit");
        end
        chk("credit.port0_stalled", last_stall, 2'b01);
        rel = 1;
        for (int i = 0; i < 4; i++) begin
            set_random();
            s_valid = 2'b11; s_rw = 2'b10; s_stall = 1'b0;
            step("credit_rel");
        end
        hold = 0;
        idle_steps("drain", 14);

        // Back-to-back writes from port 0
        for (int i = 0; i < 12; i++) begin
            set_random();
            s_valid = 2'b01; s_rw = 2'b01; s_stall = 1'b0;
            step("writes");
            chk("writes.no_stall", req_stall, 2'b00);
        end

        // mem_stall blocks all grants and holds the pointer
        for (int i = 0; i < 4; i++) begin
            set_random();
            s_valid = 2'b11; s_stall = 1'b1;
            step("mstall");
        end
        chk("mstall.req_stall", last_stall, 2'b11);
        chk("mstall.mem_valid", mem_valid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_random();
            s_valid = 2'b11; s_stall = 1'b0;
            step("mstall_rel");
        end

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 6; i++) begin
            set_random();
            step("pre_reset");
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        set_idle();
        req_valid = '0; mem_ready = 1'b0; mem_stall = 1'b0;
        check_outputs("mid_reset");
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        set_idle();
        s_valid = 2'b11; s_rw = 2'b00;
        step("post_reset");
        chk("post_reset.port0_first", last_stall, 2'b10);
        idle_steps("drain", 8);

        // Random traffic with random memory back-pressure on responses
        for (int i = 0; i < 400; i++) begin
            set_random();
            hold = ($urandom_range(0, 3) == 0);
            rel = 0;
            step("random");
        end
        hold = 0;
        idle_steps("drain", 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
